// File: rtl/if_id_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package if_id_queue_pkg;

    localparam int IFQ_DEPTH_DEFAULT = 4;
    localparam int IFQ_ADDR_W        = 32;
    localparam int IFQ_INSN_W        = 32;

    // Address path and instruction word types.
    typedef logic [IFQ_ADDR_W-1:0] instruction_addr_path_t;
    typedef logic [IFQ_INSN_W-1:0] instruction_t;

    // Canonical NOP (addi x0, x0, 0) shown to decode whenever nothing is valid.
    localparam instruction_t IFQ_NOP = 32'h0000_0013;

endpackage

// File: rtl/if_id_queue_fifo_ptr.sv
// Wrapping read/write pointer for the instruction queue; DEPTH is a power of two
// so the natural binary rollover is the modulo-DEPTH wrap.
module if_id_queue_fifo_ptr
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] ptr_q;

    // Next pointer: clear dominates, otherwise step on advance.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (adv) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    // Pointer register, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: first-word-fall-through FIFO of pc/instruction pairs
// between fetch and decode, with a flush for taken redirects.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH  = IFQ_DEPTH_DEFAULT,
    parameter int ADDR_W = IFQ_ADDR_W,
    parameter int INSN_W = IFQ_INSN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [ADDR_W-1:0]        in_pc,
    input  logic [INSN_W-1:0]        in_insn,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [INSN_W-1:0]        out_insn,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [INSN_W-1:0] NOP_W = INSN_W'(IFQ_NOP);

    logic [CNT_W-1:0]  count_d;
    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // Storage holds data only; validity is tracked by count, so no reset here.
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [INSN_W-1:0] insn_mem_q [DEPTH];

    // Handshakes depend on state only (in_ready) or state plus flush (out_valid).
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0) && !flush;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    // Occupancy update; flush wins over any push or pop in the same cycle.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    if_id_queue_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .adv (push),
        .ptr (wr_ptr)
    );

    if_id_queue_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .adv (pop),
        .ptr (rd_ptr)
    );

    // Write the accepted fetch pair at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr]   <= in_pc;
            insn_mem_q[wr_ptr] <= in_insn;
        end
    end

    // Head falls through combinationally; empty or flushing shows pc 0 / NOP.
    always_comb begin
        out_pc   = '0;
        out_insn = NOP_W;
        if (out_valid) begin
            out_pc   = pc_mem_q[rd_ptr];
            out_insn = insn_mem_q[rd_ptr];
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: vector table plus streaming, flush and
// asynchronous-reset sequences.
module tb_if_id_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int INSN_W = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] TAG  = 32'hC0DE_0000;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [ADDR_W-1:0] in_pc;
    logic [INSN_W-1:0] in_insn;
    logic              in_ready;
    logic              flush;
    logic              out_valid;
    logic [ADDR_W-1:0] out_pc;
    logic [INSN_W-1:0] out_insn;
    logic              out_ready;
    logic [2:0]        count;

    int n_checks;
    int n_errors;

    if_id_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSN_W(INSN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_insn   (in_insn),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_insn  (out_insn),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        fl;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_insn;
        logic [2:0]  e_cnt;
        logic        e_ir;
    } vec_t;

    vec_t vecs[30];

    function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic fl,
                                input logic ordy, input logic e_ov, input logic [31:0] e_pc,
                                input logic [2:0] e_cnt, input logic e_ir);
        vec_t v;
        v.iv     = iv;
        v.pc     = pc;
        v.fl     = fl;
        v.ordy   = ordy;
        v.e_ov   = e_ov;
        v.e_pc   = e_ov ? e_pc : 32'h0;
        v.e_insn = e_ov ? (TAG | e_pc) : NOP;
        v.e_cnt  = e_cnt;
        v.e_ir   = e_ir;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic fl, input logic ordy);
        in_valid  = iv;
        in_pc     = pc;
        in_insn   = TAG | pc;
        flush     = fl;
        out_ready = ordy;
    endtask

    task automatic check_all(input string tag, input logic e_ov, input logic [31:0] e_pc,
                             input logic [31:0] e_insn, input logic [2:0] e_cnt, input logic e_ir);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        check({tag, ".out_pc"},    out_pc,         e_pc);
        check({tag, ".out_insn"},  out_insn,       e_insn);
        check({tag, ".count"},     32'(count),     32'(e_cnt));
        check({tag, ".in_ready"},  32'(in_ready),  32'(e_ir));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Fill to full, fifth push ignored, drain in order.
        vecs[0]  = mk(1, 32'h00, 0, 0, 0, 32'h00, 0, 1);
        vecs[1]  = mk(1, 32'h04, 0, 0, 1, 32'h00, 1, 1);
        vecs[2]  = mk(1, 32'h08, 0, 0, 1, 32'h00, 2, 1);
        vecs[3]  = mk(1, 32'h0C, 0, 0, 1, 32'h00, 3, 1);
        vecs[4]  = mk(1, 32'h10, 0, 0, 1, 32'h00, 4, 0);
        vecs[5]  = mk(0, 32'h00, 0, 1, 1, 32'h00, 4, 0);
        vecs[6]  = mk(0, 32'h00, 0, 1, 1, 32'h04, 3, 1);
        vecs[7]  = mk(0, 32'h00, 0, 1, 1, 32'h08, 2, 1);
        vecs[8]  = mk(0, 32'h00, 0, 1, 1, 32'h0C, 1, 1);
        vecs[9]  = mk(0, 32'h00, 0, 1, 0, 32'h00, 0, 1);
        // Full with simultaneous push/pop: pop only, then push accepted.
        vecs[10] = mk(1, 32'h20, 0, 0, 0, 32'h00, 0, 1);
        vecs[11] = mk(1, 32'h24, 0, 0, 1, 32'h20, 1, 1);
        vecs[12] = mk(1, 32'h28, 0, 0, 1, 32'h20, 2, 1);
        vecs[13] = mk(1, 32'h2C, 0, 0, 1, 32'h20, 3, 1);
        vecs[14] = mk(1, 32'h30, 0, 1, 1, 32'h20, 4, 0);
        vecs[15] = mk(1, 32'h30, 0, 0, 1, 32'h24, 3, 1);
        vecs[16] = mk(0, 32'h00, 0, 1, 1, 32'h24, 4, 0);
        vecs[17] = mk(0, 32'h00, 0, 1, 1, 32'h28, 3, 1);
        vecs[18] = mk(0, 32'h00, 0, 1, 1, 32'h2C, 2, 1);
        vecs[19] = mk(0, 32'h00, 0, 1, 1, 32'h30, 1, 1);
        vecs[20] = mk(0, 32'h00, 0, 0, 0, 32'h00, 0, 1);
        // Flush with three held and a coincident push; held flush keeps it empty.
        vecs[21] = mk(1, 32'h40, 0, 0, 0, 32'h00, 0, 1);
        vecs[22] = mk(1, 32'h44, 0, 0, 1, 32'h40, 1, 1);
        vecs[23] = mk(1, 32'h48, 0, 0, 1, 32'h40, 2, 1);
        vecs[24] = mk(1, 32'h200, 1, 1, 0, 32'h00, 3, 1);
        vecs[25] = mk(1, 32'h204, 1, 1, 0, 32'h00, 0, 1);
        vecs[26] = mk(0, 32'h00, 0, 1, 0, 32'h00, 0, 1);
        vecs[27] = mk(1, 32'h50, 0, 0, 0, 32'h00, 0, 1);
        vecs[28] = mk(0, 32'h00, 0, 1, 1, 32'h50, 1, 1);
        vecs[29] = mk(0, 32'h00, 0, 0, 0, 32'h00, 0, 1);

        // Reset held low: outputs at their idle values without any clock edge.
        rst = 1'b0;
        drive(0, 32'h0, 0, 0);
        #2;
        check_all("reset", 1'b0, 32'h0, NOP, 3'd0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all("post_reset", 1'b0, 32'h0, NOP, 3'd0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].pc, vecs[i].fl, vecs[i].ordy);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_pc,
                      vecs[i].e_insn, vecs[i].e_cnt, vecs[i].e_ir);
        end

        // Streaming: push and pop every cycle, head lags input by one cycle.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(1, 32'h100 + 32'(4 * k), 0, 1);
            #1;
            if (k == 0) begin
                check_all("stream0", 1'b0, 32'h0, NOP, 3'd0, 1'b1);
            end else begin
                check_all($sformatf("stream%0d", k), 1'b1, 32'h100 + 32'(4 * (k - 1)),
                          TAG | (32'h100 + 32'(4 * (k - 1))), 3'd1, 1'b1);
            end
        end
        @(negedge clk);
        drive(0, 32'h0, 0, 1);
        #1;
        check_all("stream_tail", 1'b1, 32'h14C, TAG | 32'h14C, 3'd1, 1'b1);
        @(negedge clk);
        drive(0, 32'h0, 0, 0);
        #1;
        check_all("stream_empty", 1'b0, 32'h0, NOP, 3'd0, 1'b1);

        // Asynchronous reset mid-stream with two entries held.
        @(negedge clk);
        drive(1, 32'h60, 0, 0);
        @(negedge clk);
        drive(1, 32'h64, 0, 0);
        @(negedge clk);
        drive(0, 32'h0, 0, 0);
        #1;
        check_all("pre_async", 1'b1, 32'h60, TAG | 32'h60, 3'd2, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 32'h0, NOP, 3'd0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 32'h70, 0, 0);
        @(negedge clk);
        drive(0, 32'h0, 0, 0);
        #1;
        check_all("after_rst_push", 1'b1, 32'h70, TAG | 32'h70, 3'd1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of fetch entries held; power of two, 2..16.
REQ-002 Parameter ADDR_W, default 32, instruction address width (instructionAddrPath).
REQ-003 Parameter INSN_W, default 32, instruction width (instruction).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  fetch side presents a pc/insn pair this cycle.
REQ-007 in_pc  input  ADDR_W  address of the presented instruction.
REQ-008 in_insn  input  INSN_W  presented instruction word.
REQ-009 in_ready  output  1  queue accepts a push this cycle.
REQ-010 flush  input  1  redirect (jump/branch taken); discard all held and incoming entries.
REQ-011 out_valid  output  1  head entry available to decode.
REQ-012 out_pc  output  ADDR_W  head entry address.
REQ-013 out_insn  output  INSN_W  head entry instruction.
REQ-014 out_ready  input  1  decode consumes head entry this cycle.
REQ-015 count  output  $clog2(DEPTH)+1  number of held entries.

Function
REQ-016 Push occurs on a rising edge iff in_valid & in_ready & !flush; pop occurs iff out_valid & out_ready.
REQ-017 in_ready SHALL equal (count != DEPTH), combinational from state only; no push when full, even with a simultaneous pop.
REQ-018 out_valid SHALL equal (count != 0) & !flush; no pop completes in a flush cycle.
REQ-019 First-word-fall-through: out_pc/out_insn SHALL show the head entry combinationally from storage; push-to-out_valid latency is exactly 1 cycle.
REQ-020 When count == 0, out_pc SHALL be 0 and out_insn SHALL be 32'h00000013 (canonical NOP); same values are driven during flush.
REQ-021 Entries SHALL leave in push order; simultaneous push and pop keeps count unchanged and is legal at any non-full, non-empty occupancy.
REQ-022 Simultaneous push and pop at count == 0 is impossible (out_valid low); push alone takes effect.
REQ-023 Read/write pointers are $clog2(DEPTH) bits and SHALL wrap modulo DEPTH; count disambiguates full/empty.
REQ-024 flush SHALL, on the next edge, set count, read pointer and write pointer to 0, dropping any coincident push; storage contents need not be cleared.
REQ-025 flush has priority over push and pop; flush asserted for several cycles keeps the queue empty.
REQ-026 count SHALL never exceed DEPTH nor underflow below 0 under any input combination.

Reset
REQ-027 While rst is low: count = 0, pointers = 0, out_valid = 0, in_ready = 1, out_pc = 0, out_insn = 32'h00000013, independent of clk.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately; first push is accepted on the first rising edge after rst deasserts.

Structure
REQ-029 Types.v SHALL carry instructionAddrPath, instruction, and the NOP constant (32'h00000013); DEPTH default constant also lives there.
REQ-030 Storage is a flat register array inside if_id_queue; no sub-module required; optional sub-module fifo_ptr (pointer + wrap) is permitted.
REQ-031 No instruction decoding or address arithmetic inside the block.

Verification
REQ-032 Reset: rst low, then high; check count=0, out_valid=0, in_ready=1, out_insn=32'h00000013, out_pc=0.
REQ-033 Fill: push pc 0x00,0x04,0x08,0x0C with out_ready=0 -> count=4, in_ready=0; fifth push (pc 0x10) ignored; pop four -> pcs 0x00,0x04,0x08,0x0C in order.
REQ-034 Streaming: in_valid=out_ready=1 for 20 cycles from pc 0x100 step 4 -> out_pc lags in_pc by 1 cycle, count stays 1, pointers wrap without loss.
REQ-035 Flush: queue holds 3 entries, flush=1 with in_valid=1 (pc 0x200) -> out_valid=0 that cycle, count=0 next cycle, pc 0x200 never appears.
REQ-036 Full with pop: count=4, in_valid=1 and out_ready=1 -> pop only, count=3; next cycle push accepted, count=4.
REQ-037 Async reset mid-stream: count=2, rst pulsed low between edges -> count=0 and out_valid=0 before the next clk edge.
